// File: rtl/audio_pkg.sv
// Shared types and sample-to-PWM-level mapping for the audio output stages.
// The level mapping takes its widths as arguments so every stage can share it.
package audio_pkg;

  localparam int unsigned DEF_WIDTH    = 16;
  localparam int unsigned DEF_PWM_BITS = 8;
  localparam int unsigned DEF_CHANNELS = 2;
  localparam int unsigned DEF_VOL_BITS = 3;
  localparam int unsigned DEF_RAMP_DIV = 256;
  localparam int unsigned MAX_WIDTH    = 32;

  // Attenuation 0..2^VOL_BITS needs one bit more than the volume code.
  typedef logic [DEF_VOL_BITS:0]         att_t;
  typedef logic signed [MAX_WIDTH-1:0]   wide_sample_t;
  typedef logic [MAX_WIDTH-1:0]          wide_level_t;

  function automatic wide_level_t midscale(input int unsigned pwm_bits);
    return wide_level_t'(1) << (pwm_bits - 1);
  endfunction

  // Full attenuation parks the output at midscale (silence); otherwise the
  // shifted sample's top PWM bits become an offset-binary duty level.
  function automatic wide_level_t to_pwm_level(input wide_sample_t sample,
                                               input int unsigned  att,
                                               input int unsigned  att_max,
                                               input int unsigned  width,
                                               input int unsigned  pwm_bits);
    wide_sample_t w_shifted;
    wide_level_t  w_mask;
    wide_level_t  w_level;
    w_shifted = sample >>> att;
    w_mask    = (wide_level_t'(1) << pwm_bits) - wide_level_t'(1);
    if (att == att_max) begin
      w_level = midscale(pwm_bits);
    end else begin
      w_level = (wide_level_t'(w_shifted >>> (width - pwm_bits)) & w_mask)
                ^ midscale(pwm_bits);
    end
    return w_level;
  endfunction

endpackage

// File: rtl/volume_ramp.sv
// Click-free attenuation tracker: steps att one unit toward the volume/mute
// target on every ramp tick and drives the amplifier enable.
module volume_ramp
  import audio_pkg::*;
#(
  parameter int unsigned VOL_BITS = DEF_VOL_BITS,
  parameter int unsigned RAMP_DIV = DEF_RAMP_DIV
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [VOL_BITS-1:0] vol_in,
  input  logic                mute_in,
  output logic                tick_out,
  output logic [VOL_BITS:0]   att_out,
  output logic                sd_out
);

  localparam int unsigned AW    = VOL_BITS + 1;
  localparam int unsigned CNT_W = $clog2(RAMP_DIV);
  localparam logic [AW-1:0] ATT_MAX = {1'b1, {VOL_BITS{1'b0}}};

  logic [CNT_W-1:0] r_ramp_cnt;
  logic [AW-1:0]    r_att;
  logic             r_sd;
  logic             w_tick;
  logic [AW-1:0]    w_target;

  assign w_tick   = (r_ramp_cnt == CNT_W'(RAMP_DIV - 1));
  // Full-scale volume code maps to zero attenuation.
  assign w_target = mute_in ? ATT_MAX : {1'b0, ~vol_in};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_ramp_cnt <= '0;
      r_att      <= ATT_MAX;
      r_sd       <= 1'b0;
    end else begin
      r_ramp_cnt <= w_tick ? '0 : r_ramp_cnt + CNT_W'(1);
      if (w_tick) begin
        if (r_att < w_target) begin
          r_att <= r_att + AW'(1);
        end else if (r_att > w_target) begin
          r_att <= r_att - AW'(1);
        end
      end
      // The amplifier stays on until a mute ramp has reached full attenuation.
      r_sd <= (w_target != ATT_MAX) || (r_att != ATT_MAX);
    end
  end

  assign tick_out = w_tick;
  assign att_out  = r_att;
  assign sd_out   = r_sd;

endmodule

// File: rtl/pwm_audio_out.sv
// Multi-channel PWM speaker output: one-deep sample buffer, period-aligned
// gain updates, volume ramp and underrun reporting.
module pwm_audio_out
  import audio_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned PWM_BITS = DEF_PWM_BITS,
  parameter int unsigned CHANNELS = DEF_CHANNELS,
  parameter int unsigned VOL_BITS = DEF_VOL_BITS,
  parameter int unsigned RAMP_DIV = DEF_RAMP_DIV
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [CHANNELS*WIDTH-1:0] sample_in,
  input  logic                      sample_valid_in,
  output logic                      sample_ready_out,
  input  logic [VOL_BITS-1:0]       vol_in,
  input  logic                      mute_in,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      sd_out,
  output logic                      underrun_out
);

  localparam int unsigned ATT_MAX = 2 ** VOL_BITS;
  localparam logic [PWM_BITS-1:0] MID = PWM_BITS'(midscale(PWM_BITS));

  logic [PWM_BITS-1:0]       r_count;
  logic                      r_pend_valid;
  logic [CHANNELS*WIDTH-1:0] r_pend;
  logic [CHANNELS*WIDTH-1:0] r_last;
  logic [CHANNELS*WIDTH-1:0] w_sel;
  logic                      w_boundary;
  logic                      w_accept;
  logic                      w_tick;
  logic [VOL_BITS:0]         w_att;

  volume_ramp #(
    .VOL_BITS (VOL_BITS),
    .RAMP_DIV (RAMP_DIV)
  ) u_volume_ramp (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .vol_in   (vol_in),
    .mute_in  (mute_in),
    .tick_out (w_tick),
    .att_out  (w_att),
    .sd_out   (sd_out)
  );

  assign w_boundary       = (r_count == {PWM_BITS{1'b1}});
  assign sample_ready_out = rst_in && (!r_pend_valid || w_boundary);
  assign w_accept         = sample_valid_in && sample_ready_out;
  assign underrun_out     = rst_in && w_boundary && !r_pend_valid;
  // An empty buffer at the boundary replays the last sample.
  assign w_sel            = r_pend_valid ? r_pend : r_last;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + PWM_BITS'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_pend_valid <= 1'b0;
      r_last       <= '0;
    end else begin
      if (w_boundary && r_pend_valid) begin
        r_last <= r_pend;
      end
      // A write on the boundary refills the slot being drained this cycle.
      if (w_accept) begin
        r_pend_valid <= 1'b1;
      end else if (w_boundary) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  // NOTE: pending data is left out of reset; r_pend_valid alone decides
  // whether it is ever read.
  always_ff @(posedge clk_in) begin
    if (w_accept) begin
      r_pend <= sample_in;
    end
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [WIDTH-1:0]    w_smp;
    logic [PWM_BITS-1:0] w_next_level;
    logic [PWM_BITS-1:0] r_level;
    logic                r_pwm;

    assign w_smp        = w_sel[ch*WIDTH +: WIDTH];
    assign w_next_level = PWM_BITS'(to_pwm_level(wide_sample_t'(signed'(w_smp)),
                                                 32'(w_att), ATT_MAX,
                                                 WIDTH, PWM_BITS));

    // Level only changes on the boundary, so duty never changes mid-period.
    always_ff @(posedge clk_in) begin
      if (!rst_in) begin
        r_level <= MID;
        r_pwm   <= 1'b0;
      end else begin
        if (w_boundary) begin
          r_level <= w_next_level;
        end
        r_pwm <= (r_count < r_level);
      end
    end

    assign pwm_out[ch] = r_pwm;
  end

  a_att_moves_only_on_tick: assert property (
    @(posedge clk_in) disable iff (!rst_in) !w_tick |=> $stable(w_att)
  );

endmodule

// File: tb/tb_pwm_audio_out.sv
// Randomised scoreboard bench for pwm_audio_out against a period-level
// reference model built from queues and plain integer arithmetic.
module tb_pwm_audio_out;
  import audio_pkg::*;

  localparam int WIDTH    = 16;
  localparam int PWM_BITS = 8;
  localparam int CHANNELS = 2;
  localparam int VOL_BITS = 3;
  localparam int RAMP_DIV = 4;
  localparam int PERIOD   = 1 << PWM_BITS;
  localparam int ATT_MAX  = 1 << VOL_BITS;
  localparam int MID      = PERIOD / 2;

  logic                      clk_in = 1'b0;
  logic                      rst_in;
  logic [CHANNELS*WIDTH-1:0] sample_in;
  logic                      sample_valid_in;
  logic                      sample_ready_out;
  logic [VOL_BITS-1:0]       vol_in;
  logic                      mute_in;
  logic [CHANNELS-1:0]       pwm_out;
  logic                      sd_out;
  logic                      underrun_out;

  always #5 clk_in = ~clk_in;

  pwm_audio_out #(
    .WIDTH    (WIDTH),
    .PWM_BITS (PWM_BITS),
    .CHANNELS (CHANNELS),
    .VOL_BITS (VOL_BITS),
    .RAMP_DIV (RAMP_DIV)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .sample_in        (sample_in),
    .sample_valid_in  (sample_valid_in),
    .sample_ready_out (sample_ready_out),
    .vol_in           (vol_in),
    .mute_in          (mute_in),
    .pwm_out          (pwm_out),
    .sd_out           (sd_out),
    .underrun_out     (underrun_out)
  );

  typedef struct packed {
    logic ready;
    logic underrun;
    logic sd;
    logic after_reset;
    logic period_end;
    att_t att;
  } cyc_exp_t;

  cyc_exp_t                    cyc_q[$];
  logic [CHANNELS*PWM_BITS-1:0] lvl_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Duty level = floor(sample / 2^(att + WIDTH - PWM_BITS)) + midscale.
  function automatic logic [CHANNELS*PWM_BITS-1:0] levels_for(
      input logic [CHANNELS*WIDTH-1:0] v, input int att);
    logic [CHANNELS*PWM_BITS-1:0] r;
    logic signed [WIDTH-1:0]      t;
    int s;
    int lvl;
    r = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      t = v[ch*WIDTH +: WIDTH];
      s = t;
      if (att == ATT_MAX) lvl = MID;
      else lvl = floor_div(s, 1 << (att + WIDTH - PWM_BITS)) + MID;
      r[ch*PWM_BITS +: PWM_BITS] = lvl[PWM_BITS-1:0];
    end
    return r;
  endfunction

  // Reference model: n = clock edges since reset, pending buffer as a queue.
  int                        n;
  int                        m_att;
  bit                        m_sd;
  logic [CHANNELS*WIDTH-1:0] pend_q[$];
  logic [CHANNELS*WIDTH-1:0] last_v;

  always @(posedge clk_in) begin : p_model
    cyc_exp_t e;
    bit boundary, ready, accept, new_sd;
    int target;
    if (!rst_in) begin
      n = 0;
      pend_q.delete();
      last_v = '0;
      m_att = ATT_MAX;
      m_sd = 1'b0;
      lvl_q.delete();
      lvl_q.push_back(levels_for('0, ATT_MAX));
      e.ready = 1'b1;
      e.underrun = 1'b0;
      e.sd = 1'b0;
      e.after_reset = 1'b1;
      e.period_end = 1'b0;
      e.att = att_t'(ATT_MAX);
    end else begin
      boundary = (n % PERIOD) == PERIOD - 1;
      ready = (pend_q.size() == 0) || boundary;
      accept = sample_valid_in && ready;
      target = mute_in ? ATT_MAX : ATT_MAX - 1 - int'(vol_in);
      new_sd = (target != ATT_MAX) || (m_att != ATT_MAX);
      if (boundary) begin
        if (pend_q.size() > 0) last_v = pend_q.pop_front();
        lvl_q.push_back(levels_for(last_v, m_att));
      end
      if (accept) pend_q.push_back(sample_in);
      if ((n % RAMP_DIV) == RAMP_DIV - 1) begin
        if (target > m_att) m_att = m_att + 1;
        else if (target < m_att) m_att = m_att - 1;
      end
      m_sd = new_sd;
      n = n + 1;
      e.ready = (pend_q.size() == 0) || ((n % PERIOD) == PERIOD - 1);
      e.underrun = (pend_q.size() == 0) && ((n % PERIOD) == PERIOD - 1);
      e.sd = m_sd;
      e.after_reset = 1'b0;
      e.period_end = boundary;
      e.att = att_t'(m_att);
    end
    cyc_q.push_back(e);
  end

  // Monitor: per-cycle status checks plus per-period duty counts.
  int highs[CHANNELS];

  always @(negedge clk_in) begin : p_monitor
    cyc_exp_t e;
    logic [CHANNELS*PWM_BITS-1:0] lv;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      check("sample_ready_out", sample_ready_out, e.ready && rst_in);
      check("underrun_out", underrun_out, e.underrun && rst_in);
      check("sd_out", sd_out, e.sd);
      check("att", dut.w_att, e.att);
      if (e.after_reset) begin
        check("pwm_out in reset", pwm_out, 0);
        for (int ch = 0; ch < CHANNELS; ch++) highs[ch] = 0;
      end else begin
        for (int ch = 0; ch < CHANNELS; ch++) highs[ch] += int'(pwm_out[ch]);
        if (e.period_end) begin
          check("level queue depth", lvl_q.size(), 2);
          if (lvl_q.size() > 0) begin
            lv = lvl_q.pop_front();
            for (int ch = 0; ch < CHANNELS; ch++) begin
              check($sformatf("duty ch%0d", ch), highs[ch],
                    int'(lv[ch*PWM_BITS +: PWM_BITS]));
              highs[ch] = 0;
            end
          end
        end
      end
    end
  end

  // mode 0: random samples; 1: channel 0 = 0x4000; 2: channel 0 = 0x8000
  task automatic run(input int cycles, input int valid_pct, input int mode);
    logic [CHANNELS*WIDTH-1:0] d;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_in);
      #2;
      d = $urandom;
      if (mode == 1) d[WIDTH-1:0] = 16'h4000;
      else if (mode == 2) d[WIDTH-1:0] = 16'h8000;
      sample_in = d;
      sample_valid_in = ($urandom_range(0, 99) < valid_pct);
    end
  endtask

  initial begin
    for (int ch = 0; ch < CHANNELS; ch++) highs[ch] = 0;
    rst_in = 1'b0;
    sample_in = '0;
    sample_valid_in = 1'b0;
    vol_in = 3'd7;
    mute_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #2;
    rst_in = 1'b1;

    // Unmute ramp, then level mapping at att 0 and att 1.
    run(3 * PERIOD, 100, 1);
    run(2 * PERIOD, 100, 2);
    vol_in = 3'd6;
    run(3 * PERIOD, 100, 1);
    vol_in = 3'd7;
    run(PERIOD, 100, 0);

    // Starve the buffer.
    run(3 * PERIOD, 0, 0);

    // Random traffic with volume and mute changes mid-ramp.
    for (int k = 0; k < 16; k++) begin
      vol_in = VOL_BITS'($urandom_range(0, ATT_MAX - 1));
      mute_in = ($urandom_range(0, 3) == 0);
      run($urandom_range(40, 300), $urandom_range(0, 100), 0);
    end

    // Mute to shutdown and back.
    vol_in = 3'd7;
    mute_in = 1'b0;
    run(PERIOD, 100, 0);
    mute_in = 1'b1;
    run(2 * PERIOD, 100, 0);
    mute_in = 1'b0;
    run(PERIOD, 100, 0);

    // Reset in the middle of a period.
    run(100, 100, 0);
    rst_in = 1'b0;
    @(posedge clk_in);
    #2;
    rst_in = 1'b1;
    run(2 * PERIOD + 10, 50, 0);

    @(negedge clk_in);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_audio_out.md
# pwm_audio_out

Parametrised multi-channel PWM audio output stage. It replaces the fixed 8-bit pwm/volume_control pair on the speaker path behind the FIR filter, and adds:
- a one-deep sample buffer with a valid/ready handshake;
- gain applied only at PWM period boundaries, so output levels never change mid-period;
- a click-free volume/mute ramp;
- underrun detection and amplifier shutdown control.

## Interface
Parameters:
- WIDTH, 16, signed sample width per channel
- PWM_BITS, 8, PWM resolution; period = 2^PWM_BITS cycles; PWM_BITS ≤ WIDTH
- CHANNELS, 2, number of independent output channels
- VOL_BITS, 3, volume control width; attenuation range 0..2^VOL_BITS (MAX = 2^VOL_BITS = silence)
- RAMP_DIV, 256, clock cycles per one-step attenuation change; ≥ 2

Ports:
- clk_in  in  1  system clock (100 MHz)
- rst_in  in  1  reset, synchronous, active-low
- sample_in  in  CHANNELS*WIDTH  signed samples, channel 0 in bits [WIDTH-1:0]
- sample_valid_in  in  1  sample_in valid
- sample_ready_out  out  1  buffer can accept a sample this cycle
- vol_in  in  VOL_BITS  volume, 0 = quietest audible, all-ones = full scale
- mute_in  in  1  ramp to silence
- pwm_out  out  CHANNELS  PWM level per channel (board drives open-drain externally)
- sd_out  out  1  amplifier enable, high = on
- underrun_out  out  1  one-cycle pulse: period boundary with empty buffer

## Operation
- Reset (rst_in low at a clk_in edge) drives these values:
  - pwm_out = 0, sample_ready_out = 0, underrun_out = 0, sd_out = 0
  - period counter = 0, ramp counter = 0, pending buffer empty, last sample = 0
  - attenuation att = MAX, all level registers = midscale (2^(PWM_BITS-1))
- sample_ready_out = !pend_valid || boundary. boundary is high when the period counter = 2^PWM_BITS−1. The output is forced 0 while in reset.
- When sample_valid_in && sample_ready_out, the whole sample_in vector loads into pending and pend_valid is set.
- At each boundary:
  - If pend_valid, pending moves to the last-sample register and pend_valid clears. A sample written in the same cycle refills pending, and pend_valid stays 1.
  - If pend_valid is 0, the last sample is reused and underrun_out pulses for one cycle.
  - level[ch] is loaded from f(selected sample, att), using the att value before any same-cycle update.
- f, per channel:
  - att == MAX gives midscale.
  - Otherwise s = sample >>> att (arithmetic shift), level = s[WIDTH-1 -: PWM_BITS] with its MSB inverted (offset binary).
- Target attenuation = mute_in ? MAX : (2^VOL_BITS−1 − vol_in).
- Every RAMP_DIV cycles (ramp tick), att moves one step toward the target. A target change mid-ramp simply redirects the ramp.
- sd_out is registered: sd_out <= (target != MAX) || (att != MAX). It therefore drops only after a mute ramp has fully completed.

## Timing
- Period counter free-runs: 0..2^PWM_BITS−1, then wraps to 0.
- pwm_out[ch] is registered: pwm_out[ch] <= (count < level[ch]).
  - level = 0 gives constant low; level = 2^PWM_BITS−1 gives high for 255/256 of each period.
- Latencies:
  - Sample accepted in cycle t reaches level at the next boundary, then appears on pwm_out one cycle later.
  - vol_in/mute_in changes take effect on the next ramp tick, and in level at the following boundary.
  - Full ramp between the extremes takes MAX·RAMP_DIV cycles.
- Simultaneous events:
  - Accept plus boundary in the same cycle: the old pending sample is consumed and the new one is buffered.
  - Ramp tick plus boundary in the same cycle: level uses the old att.
- Reset asserted mid-period or mid-ramp: every register returns to its reset value at that edge. Outputs are valid on the first edge after rst_in goes high; the counter restarts at 0.

## Structure
- Package audio_pkg holds:
  - the att_t typedef (VOL_BITS+1 bits);
  - the function midscale(PWM_BITS);
  - the function to_pwm_level(sample, att), shared with future output stages.
- Sub-module volume_ramp holds:
  - ports: clk_in, rst_in, vol_in, mute_in, tick out, att_out, sd_out;
  - the ramp counter and att tracking.
- Top level holds the handshake buffer, the period counter, the level registers, and a per-channel compare generated over CHANNELS.

## Test plan
Defaults apply, with RAMP_DIV=4.

- **Unmute ramp:** rst_in low 3 cycles, then high; vol_in=7, mute_in=0.
  - sd_out rises 1 cycle after release.
  - att steps 8→0 over 32 cycles.
- **Level mapping:** sample 0x4000 on channel 0, att=0.
  - Level 192: pwm_out[0] high for 192 of 256 cycles.
  - Sample 0x8000 gives constant low.
  - Sample 0x4000 with vol_in=6 (att=1) gives level 160.
- **Underrun:** stream stops after one sample.
  - underrun_out pulses exactly at each following boundary.
  - Level holds the last value; sample_ready_out stays 1.
- **Boundary handshake:** pending is full and a valid sample arrives on the boundary cycle.
  - The sample is accepted and pend_valid stays 1.
  - No underrun pulse.
  - The new sample is used at the next boundary.
- **Mute and shutdown:** assert mute_in from att=0.
  - att reaches 8 after 32 cycles.
  - Level becomes midscale (128) at the next boundary.
  - sd_out falls 1 cycle after att=8.
  - Deasserting mute_in raises sd_out on the next cycle.
- **Reset mid-operation:** rst_in low mid-period.
  - All outputs return to reset values on the next edge.
  - Counter restarts at 0 after release.
